// File: rtl/pwm_bank.sv
// pwm_bank: multi-channel PWM with push-button duty control.
// Ports: CLK, CPU_RESETN (async, low), up_pulse/dn_pulse/sel_pulse (1-cycle pulses),
//        pwm_out[NCH], sel_ch, sel_duty (programmed duty of sel_ch), period_start.
module pwm_bank #(
    parameter int NCH   = 4,
    parameter int WIDTH = 8,
    parameter int STEP  = 5,
    parameter int DIV   = 256,
    localparam int SW   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             CLK,
    input  logic             CPU_RESETN,
    input  logic             up_pulse,
    input  logic             dn_pulse,
    input  logic             sel_pulse,
    output logic [NCH-1:0]   pwm_out,
    output logic [SW-1:0]    sel_ch,
    output logic [WIDTH:0]   sel_duty,
    output logic             period_start
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DW = WIDTH + 1;
    localparam int AW = WIDTH + 2;

    localparam logic [PW-1:0] PS_LAST  = PW'(DIV - 1);
    localparam logic [SW-1:0] SEL_LAST = SW'(NCH - 1);
    localparam logic [DW-1:0] STEP_D   = DW'(STEP);
    localparam logic [AW-1:0] STEP_A   = AW'(STEP);
    localparam logic [DW-1:0] DMAX_D   = {1'b1, {WIDTH{1'b0}}};
    localparam logic [AW-1:0] DMAX_A   = {2'b01, {WIDTH{1'b0}}};

    logic [PW-1:0]    ps_q, ps_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [SW-1:0]    sel_q, sel_d;
    logic [NCH-1:0]   pwm_q, pwm_d;
    logic             start_q;
    logic             tick;
    logic             wrap;

    logic [DW-1:0] duty_q [NCH];
    logic [DW-1:0] duty_d [NCH];
    logic [DW-1:0] act_q  [NCH];

    logic [DW-1:0] cur;
    logic [DW-1:0] nxt;
    logic [AW-1:0] sum;

    // Prescaler, period counter, selector and output compare
    always_comb begin
        tick  = (ps_q == PS_LAST);
        ps_d  = tick ? '0 : ps_q + 1'b1;
        cnt_d = tick ? cnt_q + 1'b1 : cnt_q;
        wrap  = tick && (cnt_q == '1);
        sel_d = sel_q;
        if (sel_pulse) begin
            sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
        end
        pwm_d = '0;
        for (int i = 0; i < NCH; i++) begin
            // duty of 2^WIDTH exceeds every cnt value: constant high
            pwm_d[i] = ({1'b0, cnt_q} < act_q[i]);
        end
    end

    // Saturating duty arithmetic on the channel selected before this edge
    always_comb begin
        cur = '0;
        for (int i = 0; i < NCH; i++) begin
            if (sel_q == SW'(i)) begin
                cur = duty_q[i];
            end
        end
        // Extra headroom bit keeps duty+STEP from wrapping
        sum = AW'(cur) + STEP_A;
        nxt = cur;
        if (up_pulse && !dn_pulse) begin
            nxt = (sum > DMAX_A) ? DMAX_D : sum[DW-1:0];
        end else if (dn_pulse && !up_pulse) begin
            nxt = (cur >= STEP_D) ? cur - STEP_D : '0;
        end
        for (int i = 0; i < NCH; i++) begin
            duty_d[i] = duty_q[i];
            if (sel_q == SW'(i)) begin
                duty_d[i] = nxt;
            end
        end
    end

    always_ff @(posedge CLK or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            ps_q    <= '0;
            cnt_q   <= '0;
            sel_q   <= '0;
            pwm_q   <= '0;
            start_q <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                duty_q[i] <= '0;
                act_q[i]  <= '0;
            end
        end else begin
            ps_q    <= ps_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            pwm_q   <= pwm_d;
            start_q <= wrap;
            for (int i = 0; i < NCH; i++) begin
                duty_q[i] <= duty_d[i];
                // Shadow copy taken only at the wrap keeps each period glitch-free
                if (wrap) begin
                    act_q[i] <= duty_q[i];
                end
            end
        end
    end

    assign pwm_out      = pwm_q;
    assign sel_ch       = sel_q;
    assign sel_duty     = cur;
    assign period_start = start_q;

endmodule

// File: tb/tb_pwm_bank.sv
// tb_pwm_bank: directed checks of pwm_bank with DIV=1 (STEP=5)
// and DIV=4 (STEP=64) instances sharing clock and reset.
module tb_pwm_bank;

    logic       CLK = 1'b0;
    logic       CPU_RESETN;
    logic       up1, dn1, sl1;
    logic       up4, dn4, sl4;
    logic [3:0] pwm1, pwm4;
    logic [1:0] ch1, ch4;
    logic [8:0] sd1, sd4;
    logic       ps1, ps4;

    int checks = 0;
    int errors = 0;
    int hi_c [4];
    int n;

    always #5 CLK = ~CLK;

    pwm_bank #(.NCH(4), .WIDTH(8), .STEP(5), .DIV(1)) u1 (
        .CLK(CLK), .CPU_RESETN(CPU_RESETN),
        .up_pulse(up1), .dn_pulse(dn1), .sel_pulse(sl1),
        .pwm_out(pwm1), .sel_ch(ch1), .sel_duty(sd1),
        .period_start(ps1)
    );

    pwm_bank #(.NCH(4), .WIDTH(8), .STEP(64), .DIV(4)) u4 (
        .CLK(CLK), .CPU_RESETN(CPU_RESETN),
        .up_pulse(up4), .dn_pulse(dn4), .sel_pulse(sl4),
        .pwm_out(pwm4), .sel_ch(ch4), .sel_duty(sd4),
        .period_start(ps4)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic press(input bit w, input bit u, input bit d, input bit s);
        @(negedge CLK);
        if (w) {up4, dn4, sl4} = {u, d, s};
        else   {up1, dn1, sl1} = {u, d, s};
        @(negedge CLK);
        {up1, dn1, sl1, up4, dn4, sl4} = '0;
    endtask

    task automatic press_n(input bit w, input bit u, input bit d,
                           input bit s, input int k);
        for (int j = 0; j < k; j++) press(w, u, d, s);
    endtask

    // Count high samples per channel; optionally stop at period_start
    task automatic run(input bit w, input int ncyc, input bit stop,
                       output int cyc);
        logic [3:0] v;
        bit hit;
        hit = 1'b0;
        cyc = 0;
        for (int c = 0; c < 4; c++) hi_c[c] = 0;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge CLK);
            cyc++;
            v = w ? pwm4 : pwm1;
            for (int c = 0; c < 4; c++) if (v[c]) hi_c[c]++;
            if (stop && (w ? ps4 : ps1)) begin
                hit = 1'b1;
                break;
            end
        end
        if (stop && !hit) chk("ps_timeout", 0, 1);
    endtask

    initial begin
        CPU_RESETN = 1'b0;
        {up1, dn1, sl1, up4, dn4, sl4} = '0;
        repeat (5) @(negedge CLK);
        CPU_RESETN = 1'b1;
        chk("rst_pwm", pwm1, 0);
        chk("rst_sel", ch1, 0);
        chk("rst_duty", sd1, 0);
        chk("rst_ps", ps1, 0);
        run(0, 600, 1, n);
        chk("ps_first", n, 256);
        run(0, 600, 1, n);
        chk("ps_period", n, 256);

        press_n(0, 1, 0, 0, 20);
        chk("duty_100", sd1, 100);
        run(0, 600, 1, n);
        chk("shadow_hold", hi_c[0], 0);
        run(0, 256, 0, n);
        chk("hi_100", hi_c[0], 100);
        chk("ch1_idle", hi_c[1], 0);

        press_n(0, 1, 0, 0, 60);
        chk("sat_hi", sd1, 256);
        run(0, 600, 1, n);
        run(0, 300, 0, n);
        chk("full_on", hi_c[0], 300);
        press_n(0, 0, 1, 0, 60);
        chk("sat_lo", sd1, 0);
        run(0, 600, 1, n);
        run(0, 300, 0, n);
        chk("full_off", hi_c[0], 0);

        press_n(0, 1, 0, 0, 4);
        chk("ch0_20", sd1, 20);
        press_n(0, 0, 0, 1, 3);
        chk("sel_3", ch1, 3);
        chk("ch3_init", sd1, 0);
        press_n(0, 1, 0, 0, 2);
        chk("ch3_10", sd1, 10);
        press(0, 0, 0, 1);
        chk("sel_wrap", ch1, 0);
        chk("ch0_keep", sd1, 20);
        run(0, 600, 1, n);
        run(0, 256, 0, n);
        chk("hi_ch0", hi_c[0], 20);
        chk("hi_ch1", hi_c[1], 0);
        chk("hi_ch2", hi_c[2], 0);
        chk("hi_ch3", hi_c[3], 10);

        press(0, 1, 1, 0);
        chk("updn", sd1, 20);
        press(0, 0, 0, 1);
        press(0, 1, 0, 1);
        chk("upsel_ch", ch1, 2);
        chk("upsel_ch2", sd1, 0);
        press_n(0, 0, 0, 1, 3);
        chk("upsel_ch1", ch1, 1);
        chk("upsel_duty", sd1, 5);
        press(0, 0, 1, 0);
        chk("dn_exact", sd1, 0);

        press_n(1, 1, 0, 0, 2);
        chk("d4_128", sd4, 128);
        run(1, 3000, 1, n);
        run(1, 3000, 1, n);
        chk("d4_period", n, 1024);
        chk("d4_high", hi_c[0], 512);
        run(1, 100, 0, n);
        chk("d4_mid_hi", pwm4[0], 1);
        #2 CPU_RESETN = 1'b0;
        #1;
        chk("async_pwm4", pwm4, 0);
        chk("async_pwm1", pwm1, 0);
        chk("async_duty4", sd4, 0);
        repeat (2) @(negedge CLK);
        CPU_RESETN = 1'b1;
        chk("rel_sel4", ch4, 0);
        chk("rel_duty1", sd1, 0);
        run(1, 1100, 0, n);
        chk("rel_no_pulse", hi_c[0] + hi_c[1] + hi_c[2] + hi_c[3], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
